get_r_stream_out: RTL

- Consumer end of the R = a*H result path in the 2x2 inverse datapath.
- Captures a parallel R frame (R11, R12, R21, R22; 24-bit, 8 fractional bits) when the upstream sequencer strobes it valid.
- Buffers up to FIFO_DEPTH frames and streams them out one element per beat over a valid/ready interface, in order R11, R12, R21, R22, with a last flag.
- Feeds the normalisation/output stage downstream.

---
 rtl/get_r_stream_out_if.sv | 29 ++
 rtl/get_r_stream_out.sv | 130 +++++++++++++
 2 files changed

// File: rtl/get_r_stream_out_if.sv
// Bus bundle for get_r_stream_out: parallel R-frame capture side and element stream side.
// The slave modport is the design's view; master is the producer/consumer view.
interface get_r_stream_out_if #(
  parameter int DATA_W = 24
);
  logic              I_frame_valid;
  logic              O_frame_ready;
  logic [DATA_W-1:0] I_R11;
  logic [DATA_W-1:0] I_R12;
  logic [DATA_W-1:0] I_R21;
  logic [DATA_W-1:0] I_R22;
  logic              O_r_valid;
  logic              I_r_ready;
  logic [DATA_W-1:0] O_r_data;
  logic [1:0]        O_r_idx;
  logic              O_r_last;
  logic              O_r_err;
  logic              O_overflow;

  modport slave (
    input  I_frame_valid, I_R11, I_R12, I_R21, I_R22, I_r_ready,
    output O_frame_ready, O_r_valid, O_r_data, O_r_idx, O_r_last, O_r_err, O_overflow
  );

  modport master (
    output I_frame_valid, I_R11, I_R12, I_R21, I_R22, I_r_ready,
    input  O_frame_ready, O_r_valid, O_r_data, O_r_idx, O_r_last, O_r_err, O_overflow
  );
endinterface

// File: rtl/get_r_stream_out.sv
// Captures R = a*H frames into a small FIFO and streams R11,R12,R21,R22 one element per beat.
// Optional: define R_DIAG_CHECK_EN to flag frames that are not a scaled identity on O_r_err.
module get_r_stream_out #(
  parameter int                DATA_W     = 24,
  parameter int                FIFO_DEPTH = 2,
  parameter logic [DATA_W-1:0] DIAG_TOL   = 24'd16
) (
  input logic               I_sys_clk,
  input logic               I_sys_rst,
  get_r_stream_out_if.slave io_bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, SEND0, SEND1, SEND2, SEND3} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH][4];

  logic              w_frame_ready;
  logic              w_valid;
  logic              w_push;
  logic              w_xfer;
  logic              w_pop;
  logic              w_last;
  logic              w_err;
  logic [1:0]        w_idx;
  logic [DATA_W-1:0] w_data;

  // Full blocks capture even when the last beat pops this cycle: no pass-through path.
  assign w_frame_ready = (r_count != CNT_W'(FIFO_DEPTH));
  assign w_valid       = (r_count != '0);
  assign w_push        = io_bus.I_frame_valid && w_frame_ready;
  assign w_xfer        = w_valid && io_bus.I_r_ready;
  assign w_pop         = w_xfer && (r_state == SEND3);

  always_ff @(posedge I_sys_clk) begin
    if (I_sys_rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (io_bus.I_frame_valid && !w_frame_ready) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge I_sys_clk) begin
    if (w_push) begin
      r_mem[r_wptr][0] <= io_bus.I_R11;
      r_mem[r_wptr][1] <= io_bus.I_R12;
      r_mem[r_wptr][2] <= io_bus.I_R21;
      r_mem[r_wptr][3] <= io_bus.I_R22;
    end
  end

  always_ff @(posedge I_sys_clk) begin
    if (I_sys_rst) r_state <= IDLE;
    else           r_state <= w_next_state;
  end

  // Leaving SEND3 goes straight to SEND0 when another frame is (or is just being) buffered.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_push) w_next_state = SEND0;
      SEND0:   if (w_xfer) w_next_state = SEND1;
      SEND1:   if (w_xfer) w_next_state = SEND2;
      SEND2:   if (w_xfer) w_next_state = SEND3;
      SEND3:   if (w_xfer) w_next_state = ((r_count > CNT_W'(1)) || w_push) ? SEND0 : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_idx  = 2'd0;
    w_last = 1'b0;
    case (r_state)
      SEND1:   w_idx = 2'd1;
      SEND2:   w_idx = 2'd2;
      SEND3:   begin
                 w_idx  = 2'd3;
                 w_last = 1'b1;
               end
      default: w_idx = 2'd0;
    endcase
    w_data = w_valid ? r_mem[r_rptr][w_idx] : '0;
  end

`ifdef R_DIAG_CHECK_EN
  logic [DATA_W-1:0] w_abs12;
  logic [DATA_W-1:0] w_abs21;
  logic              w_diag_err;
  logic              r_err_mem [FIFO_DEPTH];

  // Most-negative input stays at 2^(DATA_W-1) unsigned, so it always exceeds the tolerance.
  assign w_abs12    = io_bus.I_R12[DATA_W-1] ? (~io_bus.I_R12 + DATA_W'(1)) : io_bus.I_R12;
  assign w_abs21    = io_bus.I_R21[DATA_W-1] ? (~io_bus.I_R21 + DATA_W'(1)) : io_bus.I_R21;
  assign w_diag_err = (w_abs12 > DIAG_TOL) || (w_abs21 > DIAG_TOL) ||
                      (io_bus.I_R11 != io_bus.I_R22);

  always_ff @(posedge I_sys_clk) begin
    if (w_push) r_err_mem[r_wptr] <= w_diag_err;
  end

  assign w_err = w_valid && r_err_mem[r_rptr];
`else
  assign w_err = 1'b0;
`endif

  assign io_bus.O_frame_ready = w_frame_ready;
  assign io_bus.O_r_valid     = w_valid;
  assign io_bus.O_r_data      = w_data;
  assign io_bus.O_r_idx       = w_idx;
  assign io_bus.O_r_last      = w_last;
  assign io_bus.O_r_err       = w_err;
  assign io_bus.O_overflow    = r_overflow;
endmodule
